// File: rtl/seq_ctr_pkg.sv
// Shared defaults and helpers for the seq_ctr serial pattern detector.
// Fill-state width is sized to hold the values 0..PAT_LEN inclusive.
package seq_ctr_pkg;

   localparam int                      DEF_PAT_LEN = 4;
   localparam logic [DEF_PAT_LEN-1:0]  DEF_PATTERN = 4'b1011;
   localparam int                      DEF_CNT_W   = 8;

   typedef logic [DEF_CNT_W-1:0] cnt_t;

   function automatic int fill_w(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

endpackage

// File: rtl/seq_ctr_shreg.sv
// PAT_LEN-bit history shift register with a fill-count FSM (EMPTY..FULL).
// o_match looks at the post-shift state, so the top can register it on the same edge.
module seq_ctr_shreg
   import seq_ctr_pkg::*;
#(
   parameter int                   PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_bit,
   input  logic i_clr,
   output logic o_match
);

   localparam int            FW    = fill_w(PAT_LEN);
   localparam logic [FW-1:0] EMPTY = '0;
   localparam logic [FW-1:0] FULL  = FW'(PAT_LEN);

   logic [PAT_LEN-1:0] r_hist;
   logic [PAT_LEN-1:0] w_hist_nxt;
   logic [FW-1:0]      r_fill;
   logic [FW-1:0]      w_fill_nxt;

   always_comb begin
      w_hist_nxt = {r_hist[PAT_LEN-2:0], i_bit};
      w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + FW'(1);
   end

   // Fill gating keeps bits from before reset (zeros in r_hist) out of a match.
   assign o_match = (w_fill_nxt == FULL) && (w_hist_nxt == PATTERN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
         r_fill <= EMPTY;
      end else if (i_clr) begin
         r_hist <= '0;
         r_fill <= EMPTY;
      end else begin
         r_hist <= w_hist_nxt;
         r_fill <= w_fill_nxt;
      end
   end

endmodule

// File: rtl/seq_ctr.sv
// Serial pattern detector: one-cycle registered pulse on opt per PATTERN match.
// Define SEQ_CTR_COUNT_EN to add the saturating match_cnt output.
module seq_ctr
   import seq_ctr_pkg::*;
#(
   parameter int                   PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN),
   parameter bit                   OVERLAP = 1'b1,
   parameter int                   CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ip,
`ifdef SEQ_CTR_COUNT_EN
   output logic [CNT_W-1:0] match_cnt,
`endif
   output logic             opt
);

   if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_cfg
      $error("seq_ctr: PAT_LEN must be 2..16 and CNT_W >= 1");
   end

   logic w_match;
   logic w_clr;
   logic r_opt;

   // Non-overlapping mode restarts the fill count on the matching edge.
   assign w_clr = !OVERLAP && w_match;

   seq_ctr_shreg #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_bit   (ip),
      .i_clr   (w_clr),
      .o_match (w_match)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_opt <= 1'b0;
      else      r_opt <= w_match;
   end

   assign opt = r_opt;

`ifdef SEQ_CTR_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        r_cnt <= '0;
      else if (w_match && !(&r_cnt))   r_cnt <= r_cnt + CNT_W'(1);
   end

   assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_ctr.sv
// Directed bench for seq_ctr: overlapping and non-overlapping instances share one stream.
// With SEQ_CTR_COUNT_EN defined, a CNT_W=2 instance also exercises counter saturation.
module tb_seq_ctr;

   logic clk;
   logic rst;
   logic ip;
   logic opt_ov;
   logic opt_no;
   int   n_vec;
   int   n_err;

`ifdef SEQ_CTR_COUNT_EN
   logic [7:0] cnt_ov;
   logic [7:0] cnt_no;
   logic [1:0] cnt_sat;
   logic       opt_sat;
`endif

   seq_ctr #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk       (clk),
      .rst       (rst),
      .ip        (ip),
`ifdef SEQ_CTR_COUNT_EN
      .match_cnt (cnt_ov),
`endif
      .opt       (opt_ov)
   );

   seq_ctr #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
      .clk       (clk),
      .rst       (rst),
      .ip        (ip),
`ifdef SEQ_CTR_COUNT_EN
      .match_cnt (cnt_no),
`endif
      .opt       (opt_no)
   );

`ifdef SEQ_CTR_COUNT_EN
   seq_ctr #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
      .clk       (clk),
      .rst       (rst),
      .ip        (ip),
      .match_cnt (cnt_sat),
      .opt       (opt_sat)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive n bits MSB-first, checking opt of each instance after every edge.
   task automatic run(input string tag, input logic [31:0] bits, input int n,
                      input logic [31:0] eov, input logic [31:0] eno);
      for (int i = n - 1; i >= 0; i--) begin
         ip = bits[i];
         @(posedge clk);
         #1;
         chk($sformatf("%s/ov[%0d]", tag, n - 1 - i), {31'b0, opt_ov}, eov[i]);
         chk($sformatf("%s/no[%0d]", tag, n - 1 - i), {31'b0, opt_no}, eno[i]);
`ifdef SEQ_CTR_COUNT_EN
         chk($sformatf("%s/sat[%0d]", tag, n - 1 - i), {31'b0, opt_sat}, eov[i]);
`endif
      end
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b0;
      #2;
      chk({tag, "/rst_ov"}, {31'b0, opt_ov}, 32'd0);
      chk({tag, "/rst_no"}, {31'b0, opt_no}, 32'd0);
`ifdef SEQ_CTR_COUNT_EN
      chk({tag, "/rst_cnt"}, {24'b0, cnt_ov}, 32'd0);
`endif
      rst = 1'b1;
   endtask

   task automatic chk_cnt(input string tag, input int e_ov, input int e_no, input int e_sat);
`ifdef SEQ_CTR_COUNT_EN
      chk({tag, "/cnt_ov"},  {24'b0, cnt_ov},  e_ov);
      chk({tag, "/cnt_no"},  {24'b0, cnt_no},  e_no);
      chk({tag, "/cnt_sat"}, {30'b0, cnt_sat}, e_sat);
`else
      if (e_ov < 0 || e_no < 0 || e_sat < 0) chk({tag, "/cnt_arg"}, 32'd1, 32'd0);
`endif
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      ip    = 1'b0;

      // Held in reset with ip toggling: no pulse, counts stay zero.
      #1;
      chk("init/ov", {31'b0, opt_ov}, 32'd0);
      run("in_rst", 32'b10, 2, 32'b00, 32'b00);
      chk_cnt("in_rst", 0, 0, 0);

      // Basic match, then a following 1 does not re-trigger.
      rst = 1'b1;
      run("basic", 32'b10111, 5, 32'b00010, 32'b00010);
      chk_cnt("basic", 1, 1, 1);

      // Overlap vs. non-overlap on 1011011.
      pulse_reset("ovl");
      run("ovl", 32'b1011011, 7, 32'b0001001, 32'b0001000);
      chk_cnt("ovl", 2, 1, 2);

      // Asynchronous reset mid-sequence discards the partial 101.
      pulse_reset("mid");
      run("mid_pre", 32'b101, 3, 32'b000, 32'b000);
      pulse_reset("mid");
      run("mid_post", 32'b1011, 4, 32'b0001, 32'b0001);
      chk_cnt("mid", 1, 1, 1);

      // Five overlapping matches: CNT_W=2 counter saturates at 3.
      pulse_reset("sat");
      run("sat", 32'b1011011011011011, 16,
          32'b0001001001001001, 32'b0001000001000001);
      chk_cnt("sat", 5, 3, 3);

      // Quiet stream afterwards produces no pulses.
      run("quiet", 32'b0000, 4, 32'b0000, 32'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish within 50000 time units");
      $fatal(1, "timeout");
   end

endmodule
